// File: rtl/trans_sequencer.sv
// trans_sequencer: steps the address generator, issues write/read commands per address and counts completed transactions
module trans_sequencer #(
  parameter int ADDR_W = 31,
  parameter int BURST_W = 11,
  parameter int CNT_W = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               test_start_i,
  input  logic               test_abort_i,
  input  logic [1:0]         test_mode_i,
  input  logic [CNT_W-1:0]   trans_cnt_i,
  input  logic [BURST_W-1:0] burst_len_i,
  input  logic [ADDR_W-1:0]  addr_i,
  output logic               next_addr_en_o,
  output logic               cmd_valid_o,
  input  logic               cmd_ready_i,
  output logic               cmd_op_o,
  output logic [ADDR_W-1:0]  cmd_addr_o,
  output logic [BURST_W-1:0] cmd_burst_o,
  output logic               test_busy_o,
  output logic               test_done_o,
  output logic [CNT_W-1:0]   trans_done_cnt_o
);
  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT_ADV, DONE} state_t;
  state_t state, state_nx;
  logic [1:0] mode;
  logic [CNT_W-1:0] rem;
  logic go, hs, wr_first, last;
  assign go = state == IDLE && test_start_i && !test_abort_i;
  assign hs = cmd_valid_o && cmd_ready_i;
  assign wr_first = mode == 2'd2 && !cmd_op_o;
  assign last = rem == CNT_W'(1);
  assign cmd_valid_o = state == ISSUE;
  assign test_busy_o = state != IDLE;
  assign test_done_o = state == DONE;
  always_comb begin
    state_nx = state;
    next_addr_en_o = 1'b0;
    case (state)
      IDLE: state_nx = go ? (trans_cnt_i == '0 ? DONE : LOAD) : IDLE;
      LOAD, WAIT_ADV: state_nx = ISSUE;
      ISSUE: if (hs && !wr_first) begin
        state_nx = last ? DONE : WAIT_ADV;
        next_addr_en_o = !last && !test_abort_i;
      end
      default: state_nx = IDLE;
    endcase
    if (test_abort_i) state_nx = IDLE;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      mode <= '0;
      rem <= '0;
      cmd_op_o <= 1'b0;
      cmd_addr_o <= '0;
      cmd_burst_o <= '0;
      trans_done_cnt_o <= '0;
    end else begin
      state <= state_nx;
      if (go) begin
        mode <= test_mode_i;
        rem <= trans_cnt_i;
        cmd_burst_o <= burst_len_i == '0 ? BURST_W'(1) : burst_len_i;
        trans_done_cnt_o <= '0;
      end
      if (state == LOAD || state == WAIT_ADV) begin
        cmd_addr_o <= addr_i;
        cmd_op_o <= mode == 2'd1;
      end
      // the write half of a write-then-read pair only flips the op; the read half completes it
      if (hs && wr_first) cmd_op_o <= 1'b1;
      if (hs && !wr_first) begin
        rem <= rem - 1'b1;
        trans_done_cnt_o <= trans_done_cnt_o + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_trans_sequencer.sv
// tb_trans_sequencer: directed and randomized tests against a command-list reference model
module tb_trans_sequencer;
  localparam int ADDR_W = 31;
  localparam int BURST_W = 11;
  localparam int CNT_W = 32;

  typedef struct packed {
    logic op;
    logic [ADDR_W-1:0] addr;
    logic [BURST_W-1:0] burst;
  } cmd_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic test_start = 1'b0;
  logic test_abort = 1'b0;
  logic cmd_ready = 1'b0;
  logic [1:0] test_mode = '0;
  logic [CNT_W-1:0] trans_cnt = '0;
  logic [BURST_W-1:0] burst_len = '0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic [ADDR_W-1:0] addr = '0;
  logic next_addr_en, cmd_valid, cmd_op, test_busy, test_done;
  logic [ADDR_W-1:0] cmd_addr;
  logic [BURST_W-1:0] cmd_burst;
  logic [CNT_W-1:0] trans_done_cnt;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int mon_hs = 0, mon_nae = 0, mon_done = 0;
  int start_cyc = -1, first_valid_cyc = -1, last_hs_cyc = -1, done_cyc = -1;
  cmd_t expq[$];
  cmd_t e, pc;
  logic pv = 1'b0, pr = 1'b0;

  trans_sequencer #(.ADDR_W(ADDR_W), .BURST_W(BURST_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst), .test_start_i(test_start), .test_abort_i(test_abort),
    .test_mode_i(test_mode), .trans_cnt_i(trans_cnt), .burst_len_i(burst_len), .addr_i(addr),
    .next_addr_en_o(next_addr_en), .cmd_valid_o(cmd_valid), .cmd_ready_i(cmd_ready),
    .cmd_op_o(cmd_op), .cmd_addr_o(cmd_addr), .cmd_burst_o(cmd_burst), .test_busy_o(test_busy),
    .test_done_o(test_done), .trans_done_cnt_o(trans_done_cnt)
  );

  always #5 clk = ~clk;

  // incrementing address generator sharing the start pulse with the sequencer
  always @(posedge clk)
    if (rst) addr <= '0;
    else if (test_start) addr <= start_addr;
    else if (next_addr_en) addr <= addr + 1'b1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (test_start && !test_abort && !test_busy) start_cyc = cyc;
      if (cmd_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (next_addr_en) begin
        mon_nae++;
        chk("nae_only_on_handshake", {cmd_valid, cmd_ready}, 2'b11);
      end
      if (pv && !pr && cmd_valid) chk("stall_stable", {cmd_op, cmd_addr, cmd_burst}, pc);
      if (cmd_valid && cmd_ready) begin
        mon_hs++;
        last_hs_cyc = cyc;
        chk("cmd_expected", expq.size() != 0, 1);
        if (expq.size() != 0) begin
          e = expq.pop_front();
          chk("cmd", {cmd_op, cmd_addr, cmd_burst}, e);
        end
      end
      if (test_done) begin
        mon_done++;
        done_cyc = cyc;
      end
    end
    pv = cmd_valid;
    pr = cmd_ready;
    pc = '{op: cmd_op, addr: cmd_addr, burst: cmd_burst};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_test(input logic [1:0] m, input logic [CNT_W-1:0] n,
                            input logic [BURST_W-1:0] b, input logic [ADDR_W-1:0] a);
    expq.delete();
    for (longint i = 0; i < longint'(n) && i < 64; i++) begin
      cmd_t c;
      c.addr = a + ADDR_W'(i);
      c.burst = (b == '0) ? BURST_W'(1) : b;
      c.op = (m == 2'd1);
      expq.push_back(c);
      if (m == 2'd2) begin
        c.op = 1'b1;
        expq.push_back(c);
      end
    end
    mon_hs = 0; mon_nae = 0; mon_done = 0;
    first_valid_cyc = -1; last_hs_cyc = -1; done_cyc = -1;
    test_mode = m; trans_cnt = n; burst_len = b; start_addr = a;
    test_start = 1'b1;
    step();
    test_start = 1'b0;
  endtask

  task automatic run(input logic [1:0] m, input int n, input logic [BURST_W-1:0] b,
                     input logic [ADDR_W-1:0] a, input int rnd, input int stall_hs);
    int stall = 0;
    bit used = 0;
    start_test(m, CNT_W'(n), b, a);
    for (int c = 0; c < 2000 && mon_done == 0; c++) begin
      cmd_ready = (rnd != 0) ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (stall_hs >= 0 && !used && mon_hs == stall_hs && cmd_valid) begin
        stall = 5;
        used = 1;
      end
      if (stall > 0) begin
        cmd_ready = 1'b0;
        stall--;
      end
      step();
    end
    cmd_ready = 1'b0;
    chk("timeout", mon_done, 1);
    step();
    chk("done_pulses", mon_done, 1);
    chk("busy_after_done", test_busy, 0);
    chk("trans_done_cnt", trans_done_cnt, n);
    chk("handshakes", mon_hs, n * (m == 2'd2 ? 2 : 1));
    chk("cmds_left", expq.size(), 0);
    chk("nae_pulses", mon_nae, n == 0 ? 0 : n - 1);
    chk("done_timing", done_cyc, n == 0 ? start_cyc + 1 : last_hs_cyc + 1);
    chk("first_valid", first_valid_cyc, n == 0 ? -1 : start_cyc + 2);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    repeat (3) step();
    chk("reset_outputs", {cmd_valid, cmd_op, cmd_addr, cmd_burst, test_busy, test_done, next_addr_en}, '0);
    chk("reset_cnt", trans_done_cnt, 0);
    rst = 1'b0;
    step();
    run(2'd0, 4, 11'd8, 31'h100, 0, -1);
    run(2'd2, 2, 11'd5, 31'h10, 0, -1);
    run(2'd1, 3, 11'd3, 31'h200, 0, 1);
    run(2'd0, 0, 11'd0, 31'h0, 0, -1);
    run(2'd0, 1, 11'd0, 31'h40, 0, -1);
    for (int t = 0; t < 10; t++)
      run(2'($urandom), int'($urandom_range(0, 6)), 11'($urandom_range(0, 15)), 31'($urandom), 1, -1);
    // abort while the second command waits, without a handshake
    start_test(2'd0, 32'd10, 11'd4, 31'h300);
    cmd_ready = 1'b1;
    for (int c = 0; c < 20 && !(mon_hs == 1 && cmd_valid); c++) step();
    cmd_ready = 1'b0;
    test_abort = 1'b1;
    step();
    test_abort = 1'b0;
    chk("abort_busy", test_busy, 0);
    chk("abort_valid", cmd_valid, 0);
    chk("abort_cnt", trans_done_cnt, 1);
    repeat (3) step();
    chk("abort_no_done", mon_done, 0);
    chk("abort_nae", mon_nae, 1);
    // abort coinciding with a handshake still counts it
    start_test(2'd0, 32'd10, 11'd2, 31'h380);
    cmd_ready = 1'b1;
    for (int c = 0; c < 20 && !cmd_valid; c++) step();
    test_abort = 1'b1;
    step();
    test_abort = 1'b0;
    cmd_ready = 1'b0;
    chk("abort_hs_cnt", trans_done_cnt, 1);
    chk("abort_hs_nae", mon_nae, 0);
    chk("abort_hs_busy", test_busy, 0);
    step();
    chk("abort_hs_no_done", mon_done, 0);
    // start and abort together in IDLE
    test_start = 1'b1;
    test_abort = 1'b1;
    step();
    test_start = 1'b0;
    test_abort = 1'b0;
    chk("start_abort_busy", test_busy, 0);
    step();
    chk("start_abort_busy2", test_busy, 0);
    chk("start_abort_cnt", trans_done_cnt, 1);
    // maximum count must not finish early
    start_test(2'd0, '1, 11'd7, 31'h7FFF_FFFE);
    cmd_ready = 1'b1;
    for (int c = 0; c < 40 && mon_hs < 3; c++) step();
    cmd_ready = 1'b0;
    test_abort = 1'b1;
    step();
    test_abort = 1'b0;
    chk("max_cnt", trans_done_cnt, 3);
    chk("max_nae", mon_nae, 3);
    chk("max_no_done", mon_done, 0);
    // reset while waiting for the generator to advance
    start_test(2'd0, 32'd5, 11'd2, 31'h500);
    cmd_ready = 1'b1;
    for (int c = 0; c < 20 && mon_hs < 1; c++) step();
    chk("in_wait_adv", {test_busy, cmd_valid}, 2'b10);
    rst = 1'b1;
    step();
    chk("rst_outputs", {cmd_valid, cmd_op, cmd_addr, cmd_burst, test_busy, test_done, next_addr_en}, '0);
    chk("rst_cnt", trans_done_cnt, 0);
    rst = 1'b0;
    cmd_ready = 1'b0;
    step();
    run(2'd0, 3, 11'd6, 31'h600, 0, -1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
